fifo_wr_arbiter: RTL and testbench

- Single-clock arbiter in the write-clock domain of async_fifo.
- Shares the FIFO write port (wt_en/wdata) among NUM_REQ requesters.
- Policy: round-robin ownership, bounded bursts, and full/almost-full flow control, so async_fifo.overflow can never assert.
- Output wt_en/wdata connect directly to async_fifo; fifo_full/fifo_almost_full come back from it (almost_full = occupancy >= DEPTH-1, write-side view).

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the async_fifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_BURST_MAX = 4;
    localparam int unsigned IDX_W         = $clog2(DEF_NUM_REQ);
    localparam int unsigned BCNT_W        = $clog2(DEF_BURST_MAX + 1);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set request at or after ptr_i, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = IDX_W
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [PTR_W-1:0]   idx_o
);

    logic [NUM_REQ-1:0] rot;
    int unsigned        sum;

    // Rotate so bit 0 is the requester at ptr_i; the first set bit is the offset.
    always_comb begin
        rot     = NUM_REQ'({req_i, req_i} >> ptr_i);
        found_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found_o && rot[k]) begin
                found_o = 1'b1;
                sum     = 32'(ptr_i) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                idx_o = PTR_W'(sum);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing the async_fifo write port among NUM_REQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          wt_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          xfer_count
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned BC_W  = $clog2(BURST_MAX + 1);
    localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] OWNER_MAX  = PTR_W'(NUM_REQ - 1);

    arb_state_e             state_q;
    logic [PTR_W-1:0]       owner_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [BC_W-1:0]        burst_q;
    logic                   wt_en_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [CNT_WIDTH-1:0]   xfer_q;
    logic [CNT_WIDTH-1:0]   xfer_d;

    logic [PTR_W-1:0]       rr_ptr_d;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   own_req;
    logic [DATA_WIDTH-1:0]  own_data;
    logic                   can_write;
    logic                   xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        own_req  = 1'b0;
        own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_req  = req[i];
                own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // wt_en lags the transfer by a cycle, so the last free slot is already spoken for.
    assign can_write = !fifo_full && !(wt_en_q && fifo_almost_full);
    assign xfer      = (state_q == OWN) && own_req && can_write;

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i] = (state_q == OWN) && (owner_q == PTR_W'(i)) && req[i] && can_write;
        end
    end

    assign rr_ptr_d = (owner_q == OWNER_MAX) ? '0 : owner_q + 1'b1;
    assign xfer_d   = (xfer_q == '1) ? xfer_q : xfer_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        owner_q <= pick_idx;
                        burst_q <= '0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    if ((xfer && burst_q == BURST_LAST) || !own_req) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end else if (xfer) begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_en_q <= 1'b0;
            wdata_q <= '0;
            xfer_q  <= '0;
        end else begin
            wt_en_q <= xfer;
            if (xfer) begin
                wdata_q <= own_data;
                xfer_q  <= xfer_d;
            end
        end
    end

    assign wt_en      = wt_en_q;
    assign wdata      = wdata_q;
    assign owner      = owner_q;
    assign busy       = (state_q == OWN);
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter plus a BURST_MAX=1 / 3-bit counter instance and a FIFO occupancy model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [31:0]      req_data;
    logic [3:0]       gnt;
    logic             full_dir, af_dir;
    logic             fifo_full, fifo_almost_full;
    logic             wt_en;
    logic [7:0]       wdata;
    logic [IDX_W-1:0] owner;
    logic             busy;
    logic [15:0]      xfer_count;

    logic [1:0]       req_b, gnt_b;
    logic [15:0]      data_b;
    logic             wt_en_b, owner_b, busy_b;
    logic [7:0]       wdata_b;
    logic [2:0]       xfer_b;

    int  checks = 0;
    int  errors = 0;
    int  occ;
    int  writes;
    int  k_word;
    logic model_en;
    logic gprev;

    int t1_gnt   [10] = '{0, 4, 4, 4, 4, 0, 4, 4, 0, 0};
    int t1_busy  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
    int t1_wten  [10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    int t1_wdata [10] = '{0, 0, 'hA0, 'hA1, 'hA2, 'hA3, 'hA3, 'hA4, 'hA5, 'hA5};
    int t1_xfer  [10] = '{0, 0, 1, 2, 3, 4, 4, 5, 6, 6};

    always #5 clk = ~clk;

    assign fifo_full        = model_en ? (occ >= 16) : full_dir;
    assign fifo_almost_full = model_en ? (occ >= 15) : af_dir;

    // Write-side occupancy of a DEPTH=16 FIFO with a slow random reader.
    always @(posedge clk) begin
        if (!model_en) occ <= 0;
        else occ <= occ + int'(wt_en) - (((occ > 0) && ($urandom_range(0, 3) == 0)) ? 1 : 0);
    end

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .wt_en(wt_en), .wdata(wdata), .owner(owner), .busy(busy), .xfer_count(xfer_count)
    );

    fifo_wr_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(8), .BURST_MAX(1), .CNT_WIDTH(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_data(data_b), .gnt(gnt_b),
        .fifo_full(1'b0), .fifo_almost_full(1'b0),
        .wt_en(wt_en_b), .wdata(wdata_b), .owner(owner_b), .busy(busy_b), .xfer_count(xfer_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        req = '0; req_data = '0; full_dir = 1'b0; af_dir = 1'b0;
        req_b = '0; data_b = {8'h61, 8'h50}; model_en = 1'b0; writes = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_wt_en", 32'(wt_en), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_xfer",  32'(xfer_count), 0);
        chk("rst_gnt",   32'(gnt), 0);
        chk("rst_owner", 32'(owner), 0);
        tick();
        rst_n = 1'b1;

        // Burst limit: requester 2 with six words
        k_word = 0; gprev = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gprev) k_word++;
            req = (k_word < 6) ? 4'b0100 : 4'b0000;
            req_data[23:16] = 8'(32'hA0 + k_word);
            #1;
            chk("t1_gnt",   32'(gnt), t1_gnt[c]);
            chk("t1_busy",  32'(busy), t1_busy[c]);
            chk("t1_wt_en", 32'(wt_en), t1_wten[c]);
            chk("t1_wdata", 32'(wdata), t1_wdata[c]);
            chk("t1_xfer",  32'(xfer_count), t1_xfer[c]);
            gprev = gnt[2];
        end

        // Owner withdraws after two transfers
        tick(); req = 4'b1000; req_data[31:24] = 8'hB0; #1;
        chk("wd_idle_gnt", 32'(gnt), 0);
        tick(); #1;
        chk("wd_owner", 32'(owner), 3);
        chk("wd_gnt1", 32'(gnt), 8);
        tick(); req_data[31:24] = 8'hB1; #1;
        chk("wd_gnt2", 32'(gnt), 8);
        chk("wd_wdata0", 32'(wdata), 'hB0);
        tick(); req = 4'b0000; #1;
        chk("wd_gnt_drop", 32'(gnt), 0);
        chk("wd_busy_own", 32'(busy), 1);
        chk("wd_xfer", 32'(xfer_count), 8);
        tick(); req = 4'hF;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(32'hC0 + i);
        #1;
        chk("wd_idle_busy", 32'(busy), 0);
        chk("wd_owner_hold", 32'(owner), 3);
        chk("wd_wt_en", 32'(wt_en), 0);

        // Round-robin: each owner takes one word then withdraws for one cycle
        for (int k = 0; k < 5; k++) begin
            tick(); req = 4'hF; #1;
            chk("rr_owner", 32'(owner), k % 4);
            chk("rr_gnt", 32'(gnt), 1 << (k % 4));
            chk("rr_busy", 32'(busy), 1);
            tick(); req = 4'hF & ~(4'b0001 << (k % 4)); #1;
            chk("rr_gnt_off", 32'(gnt), 0);
            chk("rr_wdata", 32'(wdata), 'hC0 + (k % 4));
            tick(); req = 4'hF; #1;
            chk("rr_bubble", 32'(busy), 0);
        end

        // Full stall while requester 1 owns the port
        tick(); req = 4'b0010; full_dir = 1'b1; #1;
        chk("st_owner", 32'(owner), 1);
        chk("st_gnt", 32'(gnt), 0);
        for (int s = 0; s < 2; s++) begin
            tick(); #1;
            chk("st_hold_gnt", 32'(gnt), 0);
            chk("st_hold_wt_en", 32'(wt_en), 0);
            chk("st_hold_owner", 32'(owner), 1);
            chk("st_hold_xfer", 32'(xfer_count), 13);
        end
        tick(); full_dir = 1'b0; #1;
        chk("st_resume", 32'(gnt), 2);
        for (int s = 0; s < 3; s++) begin
            tick(); #1;
            chk("st_burst_gnt", 32'(gnt), 2);
            chk("st_wdata", 32'(wdata), 'hC1);
        end
        tick(); req = 4'b0100; #1;
        chk("st_burst_end", 32'(busy), 0);
        chk("st_xfer", 32'(xfer_count), 17);

        // Almost-full guard with a write in flight
        tick(); #1;
        chk("af_owner", 32'(owner), 2);
        chk("af_gnt0", 32'(gnt), 4);
        tick(); af_dir = 1'b1; #1;
        chk("af_inflight", 32'(wt_en), 1);
        chk("af_block", 32'(gnt), 0);
        tick(); #1;
        chk("af_wt_en_low", 32'(wt_en), 0);
        chk("af_resume", 32'(gnt), 4);
        tick(); af_dir = 1'b0; req = 4'b0000; #1;
        chk("af_xfer", 32'(xfer_count), 19);
        tick(); #1;
        chk("af_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of an owner-2 burst
        tick(); req = 4'b0100; #1;
        tick(); #1;
        chk("ar_owner", 32'(owner), 2);
        tick(); #1;
        chk("ar_wt_en_pre", 32'(wt_en), 1);
        chk("ar_xfer_pre", 32'(xfer_count), 20);
        #2 rst_n = 1'b0; req = 4'b1010;
        #1;
        chk("ar_wt_en", 32'(wt_en), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_gnt", 32'(gnt), 0);
        chk("ar_xfer", 32'(xfer_count), 0);
        chk("ar_owner0", 32'(owner), 0);
        chk("ar_wdata", 32'(wdata), 0);
        #2 rst_n = 1'b1;
        tick(); #1;
        chk("ar_first_pick", 32'(owner), 1);
        chk("ar_first_gnt", 32'(gnt), 2);
        tick(); req = 4'b0000; #1;
        tick(); #1;
        chk("ar_idle", 32'(busy), 0);

        // BURST_MAX=1, two requesters, 3-bit saturating counter
        tick(); req_b = 2'b11; #1;
        chk("b_idle", 32'(busy_b), 0);
        for (int k = 0; k < 9; k++) begin
            tick(); #1;
            chk("b_owner", 32'(owner_b), k % 2);
            chk("b_gnt", 32'(gnt_b), 1 << (k % 2));
            tick(); #1;
            chk("b_back_idle", 32'(busy_b), 0);
            chk("b_wdata", 32'(wdata_b), (k % 2 == 0) ? 'h50 : 'h61);
            chk("b_xfer", 32'(xfer_b), (k + 1 > 7) ? 7 : k + 1);
        end
        req_b = 2'b00;

        // Flags driven by the occupancy model: no write may land on a full FIFO
        tick(); model_en = 1'b1; req = 4'hF;
        for (int c = 0; c < 1500 && writes < 50; c++) begin
            tick();
            if (wt_en) begin
                writes++;
                chk("ovf", 32'(fifo_full), 0);
            end
        end
        chk("wr50", 32'(writes >= 50), 1);
        req = 4'h0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
